// File: rtl/bram_pkg.sv
// Shared constants, state encoding and mode helper for the configurable BRAM tile.
package bram_pkg;

  localparam logic [1:0] MODE_X1 = 2'd0;
  localparam logic [1:0] MODE_X2 = 2'd1;
  localparam logic [1:0] MODE_X4 = 2'd2;

  localparam int RW_READ_FIRST  = 0;
  localparam int RW_WRITE_FIRST = 1;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  // Number of address bits that select a lane inside a physical word.
  // The reserved mode 3 decodes like full width.
  function automatic logic [1:0] lane_bits(input logic [1:0] mode);
    case (mode)
      MODE_X2: return 2'd1;
      MODE_X4: return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/bram_lane_mux.sv
// Lane steering for the BRAM tile: turns a logical write into quarter write
// enables plus a replicated data word, and extracts the logical read lane.
module bram_lane_mux
  import bram_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [1:0]            mode,
  input  logic [1:0]            wlane,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [3:0]            wmask,
  output logic [3:0]            q_we,
  output logic [DATA_WIDTH-1:0] wword,
  input  logic [1:0]            rmode,
  input  logic [1:0]            rlane,
  input  logic [DATA_WIDTH-1:0] rword,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int Q = DATA_WIDTH / 4;
  localparam int H = DATA_WIDTH / 2;

  // Every lane in every mode is a whole number of quarters, so a write is
  // a quarter enable mask plus the lane data replicated across the word.
  always_comb begin
    q_we  = 4'b0000;
    wword = wdata;
    case (lane_bits(mode))
      2'd1: begin
        wword = {2{wdata[H-1:0]}};
        q_we  = wlane[0] ? 4'b1100 : 4'b0011;
      end
      2'd2: begin
        wword = {4{wdata[Q-1:0]}};
        q_we  = 4'b0001 << wlane;
      end
      default: begin
        wword = wdata;
        q_we  = wmask;
      end
    endcase
  end

  // Pick the addressed lane out of the registered word, zero-extended.
  always_comb begin
    rdata = '0;
    case (lane_bits(rmode))
      2'd1:    rdata[H-1:0] = rlane[0] ? rword[DATA_WIDTH-1:H] : rword[H-1:0];
      2'd2:    rdata[Q-1:0] = rword[rlane*Q +: Q];
      default: rdata        = rword;
    endcase
  end

endmodule

// File: rtl/bram_cfg.sv
// Simple-dual-port BRAM tile with registered read, configurable aspect ratio,
// quarter write masking, selectable collision policy and a clear-on-reset
// sequencer that zeroes every physical word before accepting traffic.
module bram_cfg
  import bram_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 8,
  parameter int RW_MODE    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            cfg_mode,
  input  logic                  ren,
  input  logic [ADDR_WIDTH+1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid,
  input  logic                  we,
  input  logic [ADDR_WIDTH+1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [3:0]            wmask,
  output logic                  busy
);

  localparam int Q = DATA_WIDTH / 4;

  state_t                  state_reg;
  logic [ADDR_WIDTH-1:0]   clr_ptr_reg;
  logic                    rvalid_reg;
  logic [1:0]              rd_lane_reg;
  logic [1:0]              rd_mode_reg;
  logic [DATA_WIDTH-1:0]   rd_word;

  logic [ADDR_WIDTH-1:0]   waddr_word, raddr_word;
  logic [1:0]              wlane, rlane;
  logic [3:0]              lane_we;
  logic [DATA_WIDTH-1:0]   lane_wword;
  logic                    clearing, wr_fire, rd_fire;
  logic [3:0]              q_wr;
  logic [ADDR_WIDTH-1:0]   wr_idx;
  logic [DATA_WIDTH-1:0]   wr_word;

  // Split logical addresses into physical word index and lane; high bits
  // beyond the logical depth simply fall off.
  always_comb begin
    waddr_word = waddr[ADDR_WIDTH-1:0];
    raddr_word = raddr[ADDR_WIDTH-1:0];
    wlane      = 2'd0;
    rlane      = 2'd0;
    case (lane_bits(cfg_mode))
      2'd1: begin
        waddr_word = waddr[ADDR_WIDTH:1];
        raddr_word = raddr[ADDR_WIDTH:1];
        wlane      = {1'b0, waddr[0]};
        rlane      = {1'b0, raddr[0]};
      end
      2'd2: begin
        waddr_word = waddr[ADDR_WIDTH+1:2];
        raddr_word = raddr[ADDR_WIDTH+1:2];
        wlane      = waddr[1:0];
        rlane      = raddr[1:0];
      end
      default: ;
    endcase
  end

  bram_lane_mux #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_lane_mux (
    .mode  (cfg_mode),
    .wlane (wlane),
    .wdata (wdata),
    .wmask (wmask),
    .q_we  (lane_we),
    .wword (lane_wword),
    .rmode (rd_mode_reg),
    .rlane (rd_lane_reg),
    .rword (rd_word),
    .rdata (rdata)
  );

  assign clearing = (state_reg == ST_CLEAR) && !rst;
  assign wr_fire  = (state_reg == ST_READY) && !rst && we;
  assign rd_fire  = (state_reg == ST_READY) && !rst && ren;

  // The clear sequencer borrows the write port; user traffic is locked out.
  always_comb begin
    q_wr    = 4'b0000;
    wr_idx  = waddr_word;
    wr_word = lane_wword;
    if (clearing) begin
      q_wr    = 4'b1111;
      wr_idx  = clr_ptr_reg;
      wr_word = '0;
    end else if (wr_fire) begin
      q_wr = lane_we;
    end
  end

  // Clear FSM: one word per cycle from pointer 0, READY after the last word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_CLEAR;
      clr_ptr_reg <= '0;
    end else if (state_reg == ST_CLEAR) begin
      clr_ptr_reg <= clr_ptr_reg + ADDR_WIDTH'(1);
      if (&clr_ptr_reg) state_reg <= ST_READY;
    end
  end

  assign busy = (state_reg == ST_CLEAR);

  // Read side bookkeeping: valid pulse plus the lane/mode used for extraction.
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_reg  <= 1'b0;
      rd_lane_reg <= 2'd0;
      rd_mode_reg <= MODE_X1;
    end else begin
      rvalid_reg <= rd_fire;
      if (rd_fire) begin
        rd_lane_reg <= rlane;
        rd_mode_reg <= cfg_mode;
      end
    end
  end

  assign rvalid = rvalid_reg;

  // One narrow memory per quarter so each quarter has its own write enable.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_quarter
      logic [Q-1:0] mem [2**ADDR_WIDTH];
      logic [Q-1:0] rd_q_reg;

      // Quarter write port.
      always_ff @(posedge clk) begin
        if (q_wr[gi]) mem[wr_idx] <= wr_word[gi*Q +: Q];
      end

      // Registered quarter read; write-first bypasses freshly written data.
      always_ff @(posedge clk) begin
        if (rst) begin
          rd_q_reg <= '0;
        end else if (rd_fire) begin
          if (RW_MODE == RW_WRITE_FIRST && q_wr[gi] && wr_idx == raddr_word)
            rd_q_reg <= wr_word[gi*Q +: Q];
          else
            rd_q_reg <= mem[raddr_word];
        end
      end

      assign rd_word[gi*Q +: Q] = rd_q_reg;
    end
  endgenerate

endmodule

// File: tb/tb_bram_cfg.sv
// Self-checking bench for bram_cfg: one read-first and one write-first tile
// share stimulus; a word-array model predicts both every cycle, and directed
// sequences pin literal results.
module tb_bram_cfg;

  localparam int AW    = 6;
  localparam int DW    = 8;
  localparam int DEPTH = 64;
  localparam int Q     = DW / 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    cfg_mode = 2'd0;
  logic          ren = 1'b0, we = 1'b0;
  logic [AW+1:0] raddr = '0, waddr = '0;
  logic [DW-1:0] wdata = '0;
  logic [3:0]    wmask = '0;

  logic [DW-1:0] rdata_rf, rdata_wf;
  logic          rvalid_rf, rvalid_wf, busy_rf, busy_wf;

  always #5 clk = ~clk;

  bram_cfg #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RW_MODE(0)) u_rf (
    .clk(clk), .rst(rst), .cfg_mode(cfg_mode), .ren(ren), .raddr(raddr),
    .rdata(rdata_rf), .rvalid(rvalid_rf), .we(we), .waddr(waddr),
    .wdata(wdata), .wmask(wmask), .busy(busy_rf));

  bram_cfg #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RW_MODE(1)) u_wf (
    .clk(clk), .rst(rst), .cfg_mode(cfg_mode), .ren(ren), .raddr(raddr),
    .rdata(rdata_wf), .rvalid(rvalid_wf), .we(we), .waddr(waddr),
    .wdata(wdata), .wmask(wmask), .busy(busy_wf));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [DW-1:0] mem_m [DEPTH];
  int            clr_left   = 0;
  bit            live       = 1'b0;
  bit            exp_rvalid = 1'b0;
  logic [DW-1:0] exp_rf = '0, exp_wf = '0;
  logic [DW-1:0] pre_v, post_v;

  function automatic int mbits(input logic [1:0] mode);
    return (mode == 2'd1) ? 1 : (mode == 2'd2) ? 2 : 0;
  endfunction

  function automatic logic [DW-1:0] m_read(input logic [AW+1:0] a, input logic [1:0] mode);
    int m, w, idx, lane;
    m    = mbits(mode);
    w    = DW >> m;
    idx  = (int'(a) >> m) % DEPTH;
    lane = int'(a) % (1 << m);
    return DW'((int'(mem_m[idx]) >> (lane * w)) & ((1 << w) - 1));
  endfunction

  task automatic m_write(input logic [AW+1:0] a, input logic [DW-1:0] d,
                         input logic [3:0] mk, input logic [1:0] mode);
    int m, w, idx, lane;
    m    = mbits(mode);
    w    = DW >> m;
    idx  = (int'(a) >> m) % DEPTH;
    lane = int'(a) % (1 << m);
    for (int b = 0; b < DW; b++) begin
      if (m == 0) begin
        if (mk[b / Q]) mem_m[idx][b] = d[b];
      end else if (b >= lane * w && b < (lane + 1) * w) begin
        mem_m[idx][b] = d[b - lane * w];
      end
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
      clr_left   = DEPTH;
      exp_rvalid = 1'b0;
      exp_rf     = '0;
      exp_wf     = '0;
      live       = 1'b1;
    end else if (clr_left > 0) begin
      clr_left--;
      exp_rvalid = 1'b0;
    end else begin
      if (ren) pre_v = m_read(raddr, cfg_mode);
      if (we) m_write(waddr, wdata, wmask, cfg_mode);
      if (ren) begin
        post_v = m_read(raddr, cfg_mode);
        exp_rf = pre_v;
        exp_wf = post_v;
      end
      exp_rvalid = ren;
    end
  end

  always @(negedge clk) begin
    if (live) begin
      chk("busy_rf",   32'(busy_rf),   32'(clr_left > 0));
      chk("busy_wf",   32'(busy_wf),   32'(clr_left > 0));
      chk("rvalid_rf", 32'(rvalid_rf), 32'(exp_rvalid));
      chk("rvalid_wf", 32'(rvalid_wf), 32'(exp_rvalid));
      chk("rdata_rf",  32'(rdata_rf),  32'(exp_rf));
      chk("rdata_wf",  32'(rdata_wf),  32'(exp_wf));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW+1:0] a, input logic [DW-1:0] d, input logic [3:0] mk);
    waddr = a; wdata = d; wmask = mk; we = 1'b1;
    tick();
    we = 1'b0;
  endtask

  task automatic rd_lit(input string name, input logic [AW+1:0] a, input logic [DW-1:0] e);
    raddr = a; ren = 1'b1;
    tick();
    ren = 1'b0;
    @(negedge clk);
    chk({name, "_rf"}, 32'(rdata_rf), 32'(e));
    chk({name, "_wf"}, 32'(rdata_wf), 32'(e));
    chk({name, "_valid"}, 32'(rvalid_rf & rvalid_wf), 32'd1);
  endtask

  task automatic count_busy(output int n);
    n = 0;
    ren = 1'b1;
    raddr = (AW + 2)'($urandom);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (busy_rf) n++;
      else break;
    end
    ren = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    tick();
    @(negedge clk);
    chk("reset_busy",   32'(busy_rf),  32'd1);
    chk("reset_rvalid", 32'(rvalid_wf), 32'd0);
    chk("reset_rdata",  32'(rdata_rf), 32'd0);
    tick();
    rst = 1'b0;
    count_busy(n);
    chk("busy_len_power_up", 32'(n), 32'd64);

    // Preload ones, then reset must clear everything.
    cfg_mode = 2'd0;
    for (int i = 0; i < DEPTH; i++) wr((AW + 2)'(i), 8'hFF, 4'hF);
    rd_lit("preload", 8'd17, 8'hFF);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    count_busy(n);
    chk("busy_len_after_rst", 32'(n), 32'd64);
    for (int i = 0; i < DEPTH; i++) rd_lit("cleared_word", (AW + 2)'(i), 8'h00);

    // Masked full-width write.
    wr(8'd3, 8'hA5, 4'b1111);
    wr(8'd3, 8'h3C, 4'b0011);
    rd_lit("masked_write", 8'd3, 8'hAC);
    wr(8'd3, 8'h77, 4'b0000);
    rd_lit("mask_zero_noop", 8'd3, 8'hAC);

    // Quarter-width lanes.
    cfg_mode = 2'd2;
    for (int i = 0; i < 4; i++) wr(8'(8 + i), 8'(i), 4'b0000);
    rd_lit("x4_lane_read", 8'd10, 8'h02);
    cfg_mode = 2'd0;
    rd_lit("x4_packed_word", 8'd2, 8'hE4);

    // Same-word collision.
    wr(8'd5, 8'h11, 4'hF);
    waddr = 8'd5; wdata = 8'h22; wmask = 4'hF; we = 1'b1;
    raddr = 8'd5; ren = 1'b1;
    tick();
    we = 1'b0; ren = 1'b0;
    @(negedge clk);
    chk("collision_read_first",  32'(rdata_rf), 32'h11);
    chk("collision_write_first", 32'(rdata_wf), 32'h22);
    rd_lit("after_collision", 8'd5, 8'h22);

    // Reset in the middle of the clear sequence restarts it.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 30; i++) @(negedge clk);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    count_busy(n);
    chk("busy_len_mid_clear_rst", 32'(n), 32'd64);

    // Half-width aliasing and streaming reads.
    cfg_mode = 2'd1;
    wr(8'd0, 8'h0F, 4'b0000);
    raddr = 8'd128; ren = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 3) ren = 1'b0;
      @(negedge clk);
      chk("stream_rvalid", 32'(rvalid_rf & rvalid_wf), 32'd1);
      chk("stream_rdata",  32'(rdata_rf), 32'h0F);
    end

    // Randomised traffic in every mode, biased toward colliding addresses.
    for (int p = 0; p < 4; p++) begin
      cfg_mode = 2'(p);
      for (int c = 0; c < 400; c++) begin
        we    = 1'($urandom_range(0, 1));
        ren   = 1'($urandom_range(0, 1));
        waddr = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 15)) : 8'($urandom);
        raddr = ($urandom_range(0, 3) == 0) ? waddr :
                ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 15)) : 8'($urandom);
        wdata = 8'($urandom);
        wmask = 4'($urandom);
        tick();
      end
      we = 1'b0; ren = 1'b0;
      tick();
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
